// File: rtl/multicycle_controller.sv
// ============================================================================
// Module   : multicycle_controller
// Purpose  : Multi-cycle RV32 sequencer with handshaked I/D memories and traps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller #(
    parameter int MEM_TIMEOUT = 15,
    parameter int RETIRE_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          opcode,
    input  logic                zero,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    output logic                imem_req,
    output logic                ir_we,
    output logic                pc_we,
    output logic                pc_sel,
    output logic                reg_wr,
    output logic                ALUSrc,
    output logic [1:0]          ALUOp,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic                memtoReg,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [2:0]          state,
    output logic [RETIRE_W-1:0] retired
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] c_WAIT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    localparam logic [6:0] c_OP_R   = 7'b0110011;
    localparam logic [6:0] c_OP_I   = 7'b0010011;
    localparam logic [6:0] c_OP_LW  = 7'b0000011;
    localparam logic [6:0] c_OP_SW  = 7'b0100011;
    localparam logic [6:0] c_OP_BEQ = 7'b1100011;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd7
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      wait_q, wait_d;
    logic [1:0]            cause_q, cause_d;
    logic [RETIRE_W-1:0]   retired_q;
    logic                  retire;
    logic                  waiting;
    logic                  timeout_hit;
    logic                  op_r, op_i, op_lw, op_sw, op_beq;

    assign op_r   = (opcode == c_OP_R);
    assign op_i   = (opcode == c_OP_I);
    assign op_lw  = (opcode == c_OP_LW);
    assign op_sw  = (opcode == c_OP_SW);
    assign op_beq = (opcode == c_OP_BEQ);

    assign timeout_hit = (MEM_TIMEOUT > 0) && (wait_q == c_WAIT_LAST);

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        retire   = 1'b0;
        waiting  = 1'b0;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 1'b0;
        reg_wr   = 1'b0;
        ALUSrc   = 1'b0;
        ALUOp    = 2'b00;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        memtoReg = 1'b0;
        trap     = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    cause_d = 2'd1;
                end else begin
                    waiting = 1'b1;
                end
            end
            S_DECODE: begin
                if (op_r || op_i || op_lw || op_sw || op_beq) begin
                    state_d = S_EXECUTE;
                end else begin
                    state_d = S_TRAP;
                    cause_d = 2'd2;
                end
            end
            S_EXECUTE: begin
                if (op_r) begin
                    ALUOp   = 2'b10;
                    state_d = S_WRITEBACK;
                end else if (op_i) begin
                    ALUSrc  = 1'b1;
                    ALUOp   = 2'b11;
                    state_d = S_WRITEBACK;
                end else if (op_lw || op_sw) begin
                    ALUSrc  = 1'b1;
                    state_d = S_MEM;
                end else if (op_beq) begin
                    ALUOp   = 2'b01;
                    pc_we   = 1'b1;
                    pc_sel  = zero;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_TRAP;
                    cause_d = 2'd2;
                end
            end
            S_MEM: begin
                ALUSrc = 1'b1;
                mem_rd = op_lw;
                mem_wr = op_sw;
                if (dmem_ready) begin
                    if (op_lw) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    cause_d = 2'd3;
                end else begin
                    waiting = 1'b1;
                end
            end
            S_WRITEBACK: begin
                reg_wr   = 1'b1;
                memtoReg = op_lw;
                if (op_r) begin
                    ALUOp = 2'b10;
                end else if (op_i) begin
                    ALUSrc = 1'b1;
                    ALUOp  = 2'b11;
                end
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase
        // Counter only advances while parked in a request state without ready.
        wait_d = waiting ? (wait_q + CNT_W'(1)) : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            cause_q   <= 2'd0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
            if (retire) begin
                retired_q <= retired_q + RETIRE_W'(1);
            end
        end
    end

    assign state      = state_q;
    assign trap_cause = cause_q;
    assign retired    = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// Module   : tb_multicycle_controller
// Purpose  : Directed self-checking bench for multicycle_controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

    localparam logic [6:0] c_OP_R   = 7'b0110011;
    localparam logic [6:0] c_OP_LW  = 7'b0000011;
    localparam logic [6:0] c_OP_SW  = 7'b0100011;
    localparam logic [6:0] c_OP_BEQ = 7'b1100011;
    localparam logic [6:0] c_OP_BAD = 7'b1111111;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic        zero, imem_ready, dmem_ready;
    logic        imem_req, ir_we, pc_we, pc_sel, reg_wr, ALUSrc;
    logic [1:0]  ALUOp;
    logic        mem_rd, mem_wr, memtoReg, trap;
    logic [1:0]  trap_cause;
    logic [2:0]  state;
    logic [31:0] retired;

    // Narrow-counter instance shares stimulus so its retire count wraps quickly.
    logic        s_imem_req, s_ir_we, s_pc_we, s_pc_sel, s_reg_wr, s_ALUSrc;
    logic [1:0]  s_ALUOp;
    logic        s_mem_rd, s_mem_wr, s_memtoReg, s_trap;
    logic [1:0]  s_trap_cause;
    logic [2:0]  s_state;
    logic [1:0]  s_retired;

    int n_cmp = 0;
    int n_err = 0;
    int exp_ret = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.MEM_TIMEOUT(15), .RETIRE_W(32)) u_dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .reg_wr(reg_wr), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .memtoReg(memtoReg), .trap(trap),
        .trap_cause(trap_cause), .state(state), .retired(retired)
    );

    multicycle_controller #(.MEM_TIMEOUT(15), .RETIRE_W(2)) u_dut_small (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(s_imem_req), .ir_we(s_ir_we), .pc_we(s_pc_we), .pc_sel(s_pc_sel),
        .reg_wr(s_reg_wr), .ALUSrc(s_ALUSrc), .ALUOp(s_ALUOp), .mem_rd(s_mem_rd),
        .mem_wr(s_mem_wr), .memtoReg(s_memtoReg), .trap(s_trap),
        .trap_cause(s_trap_cause), .state(s_state), .retired(s_retired)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        step();
        reset = 1'b1;
        #1;
        exp_ret = 0;
    endtask

    initial begin
        reset      = 1'b0;
        opcode     = 7'd0;
        zero       = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        step();
        step();
        check("rst_state", 32'(state), 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_trap", 32'(trap), 32'd0);
        check("rst_cause", 32'(trap_cause), 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd1);
        check("rst_strobes", 32'({ir_we, pc_we, reg_wr, mem_rd, mem_wr}), 32'd0);

        // R-type, zero-wait fetch: F D E WB
        reset = 1'b1; imem_ready = 1'b1; opcode = c_OP_R; #1;
        check("r_fetch_irwe", 32'(ir_we), 32'd1);
        step(); check("r_decode", 32'(state), 32'd1);
        step(); check("r_exec", 32'(state), 32'd2);
        check("r_exec_aluop", 32'(ALUOp), 32'd2);
        check("r_exec_alusrc", 32'(ALUSrc), 32'd0);
        step(); check("r_wb", 32'(state), 32'd4);
        check("r_wb_regwr_pcwe", 32'({reg_wr, pc_we, memtoReg}), 32'b110);
        step(); exp_ret++;
        check("r_done_state", 32'(state), 32'd0);
        check("r_retired", retired, 32'(exp_ret));

        // BEQ taken then not taken: 3 cycles each
        opcode = c_OP_BEQ;
        for (int z = 1; z >= 0; z--) begin
            zero = z[0];
            step(); step();
            check("beq_exec", 32'(state), 32'd2);
            check("beq_pcwe", 32'(pc_we), 32'd1);
            check("beq_pcsel", 32'(pc_sel), 32'(z));
            check("beq_aluop", 32'(ALUOp), 32'd1);
            step(); exp_ret++;
            check("beq_done", 32'(state), 32'd0);
            check("beq_retired", retired, 32'(exp_ret));
        end

        // LW with dmem_ready on the fourth MEM cycle: 8 cycles total
        opcode = c_OP_LW; zero = 1'b0;
        step(); step();
        check("lw_exec_src_op", 32'({ALUSrc, ALUOp}), 32'b100);
        step();
        for (int i = 0; i < 3; i++) begin
            check("lw_mem_state", 32'(state), 32'd3);
            check("lw_mem_rd", 32'(mem_rd), 32'd1);
            step();
        end
        dmem_ready = 1'b1; #1;
        check("lw_mem_rd_ready", 32'(mem_rd), 32'd1);
        step(); dmem_ready = 1'b0; #1;
        check("lw_wb", 32'(state), 32'd4);
        check("lw_wb_memtoreg_regwr", 32'({memtoReg, reg_wr}), 32'b11);
        step(); exp_ret++;
        check("lw_done", 32'(state), 32'd0);
        check("lw_retired", retired, 32'(exp_ret));
        check("small_wrap_lw", 32'(s_retired), 32'(exp_ret % 4));

        // Fetch ready in the last permitted waiting cycle is accepted
        imem_ready = 1'b0; opcode = c_OP_SW; #1;
        for (int i = 0; i < 14; i++) begin
            check("fetch_wait", 32'(state), 32'd0);
            step();
        end
        imem_ready = 1'b1; #1;
        check("fetch_late_irwe", 32'(ir_we), 32'd1);
        step();
        check("fetch_late_decode", 32'(state), 32'd1);

        // SW with no dmem_ready: 15 MEM cycles then data-timeout trap
        step(); step();
        for (int i = 0; i < 15; i++) begin
            check("sw_mem_wr", 32'({state, mem_wr}), 32'({3'd3, 1'b1}));
            step();
        end
        check("sw_to_state", 32'(state), 32'd7);
        check("sw_to_trap", 32'(trap), 32'd1);
        check("sw_to_cause", 32'(trap_cause), 32'd3);
        check("sw_to_strobes", 32'({imem_req, ir_we, pc_we, reg_wr, mem_rd, mem_wr}), 32'd0);
        step();
        check("trap_sticky", 32'(state), 32'd7);

        reset_pulse();
        check("trap_rst_state", 32'(state), 32'd0);
        check("trap_rst_flags", 32'({trap, trap_cause}), 32'd0);
        check("trap_rst_retired", retired, 32'd0);

        // Illegal opcode traps out of DECODE
        opcode = c_OP_BAD; imem_ready = 1'b1;
        step(); step();
        check("illegal_state", 32'(state), 32'd7);
        check("illegal_cause", 32'(trap_cause), 32'd2);
        reset_pulse();
        check("illegal_rst", 32'({state, trap}), 32'd0);

        // Reset in the middle of an SW MEM phase
        opcode = c_OP_SW;
        step(); step(); step();
        check("midmem_state", 32'({state, mem_wr}), 32'({3'd3, 1'b1}));
        reset_pulse();
        check("midmem_rst", 32'({state, mem_wr}), 32'd0);

        // Fetch timeout
        imem_ready = 1'b0;
        for (int i = 0; i < 15; i++) step();
        check("fetch_to_state", 32'(state), 32'd7);
        check("fetch_to_cause", 32'(trap_cause), 32'd1);
        reset_pulse();

        // Back-to-back BEQs wrap the 2-bit retire counter
        imem_ready = 1'b1; opcode = c_OP_BEQ;
        for (int k = 1; k <= 5; k++) begin
            step(); step(); step();
            check("wrap_retired", retired, 32'(k));
            check("wrap_small", 32'(s_retired), 32'(k % 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
